// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latching prioritized interrupt controller
//
// Latches rising edges of device interrupt lines into a pending register,
// masks them, and presents the lowest-index pending request one-hot on
// io_out for the control unit. It tracks kernel entry and return, records
// the interrupted PC and the serviced cause, and holds io_out at zero while
// the kernel runs, so requests cannot nest.
//
// Ports:
//   CLK, Reset     clock (rising edge), synchronous active-high reset
//   irq_lines      raw level interrupt lines from the devices
//   mask_we/wdata  mask register write (1 = source enabled)
//   ack_we/wdata   write-1-to-clear strobe for pending
//   kernel_enter   control unit is in its kernel-entry state (one cycle)
//   state_fetch    control unit is in Fetch
//   pc             current program counter
//   io_out         one-hot request to the control unit (0 = none)
//   pending        latched edge flags
//   cause          index of the source being serviced
//   saved_pc       PC captured at kernel entry
//   in_kernel      kernel active
//   return_pulse   one-cycle pulse on kernel return
module interrupt_controller #(
   parameter int          NUM_SRC   = 16,
   parameter logic [15:0] RETURN_PC = 16'd255
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [NUM_SRC-1:0] irq_lines,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic               ack_we,
   input  logic [NUM_SRC-1:0] ack_wdata,
   input  logic               kernel_enter,
   input  logic               state_fetch,
   input  logic [15:0]        pc,
   output logic [NUM_SRC-1:0] io_out,
   output logic [NUM_SRC-1:0] pending,
   output logic [3:0]         cause,
   output logic [15:0]        saved_pc,
   output logic               in_kernel,
   output logic               return_pulse
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQUEST = 2'd1,
      S_KERNEL  = 2'd2,
      S_RETURN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] prev_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] io_out_q, io_out_d;
   logic [3:0]         cause_q, cause_d;
   logic [15:0]        saved_pc_q, saved_pc_d;
   logic               in_kernel_q, in_kernel_d;
   logic               return_pulse_q, return_pulse_d;

   logic [NUM_SRC-1:0] edges;
   logic [NUM_SRC-1:0] masked;
   logic [NUM_SRC-1:0] prio;
   logic [NUM_SRC-1:0] clr;
   logic [3:0]         io_idx;

   assign edges  = irq_lines & ~prev_q;
   assign masked = pending_q & mask_q;

   // Lowest set index wins: scan downward so the last hit is the lowest bit.
   always_comb begin
      prio = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (masked[i]) begin
            prio    = '0;
            prio[i] = 1'b1;
         end
      end
   end

   // Index of the bit currently presented to the control unit.
   always_comb begin
      io_idx = 4'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (io_out_q[i]) io_idx = 4'(i);
      end
   end

   always_comb begin
      state_d        = state_q;
      io_out_d       = '0;
      cause_d        = cause_q;
      saved_pc_d     = saved_pc_q;
      in_kernel_d    = in_kernel_q;
      return_pulse_d = 1'b0;
      clr            = ack_we ? ack_wdata : '0;

      case (state_q)
         S_IDLE: begin
            if (masked != '0) begin
               state_d  = S_REQUEST;
               io_out_d = prio;
            end
         end
         S_REQUEST: begin
            if (masked == '0) begin
               state_d = S_IDLE;
            end else if (kernel_enter) begin
               cause_d     = io_idx;
               saved_pc_d  = pc;
               clr         = clr | io_out_q;
               in_kernel_d = 1'b1;
               state_d     = S_KERNEL;
            end else begin
               io_out_d = prio;
            end
         end
         S_KERNEL: begin
            if (state_fetch && (pc == RETURN_PC)) begin
               return_pulse_d = 1'b1;
               state_d        = S_RETURN;
            end
         end
         S_RETURN: begin
            in_kernel_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // An edge on a bit being cleared in the same cycle wins.
      pending_d = (pending_q & ~clr) | edges;
   end

   always_ff @(posedge CLK) begin
      // prev_q tracks the lines even in reset so lines held high through
      // reset produce no edge afterwards.
      prev_q <= irq_lines;
      if (Reset) begin
         state_q        <= S_IDLE;
         pending_q      <= '0;
         mask_q         <= '0;
         io_out_q       <= '0;
         cause_q        <= 4'd0;
         saved_pc_q     <= 16'd0;
         in_kernel_q    <= 1'b0;
         return_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         if (mask_we) mask_q <= mask_wdata;
         io_out_q       <= io_out_d;
         cause_q        <= cause_d;
         saved_pc_q     <= saved_pc_d;
         in_kernel_q    <= in_kernel_d;
         return_pulse_q <= return_pulse_d;
      end
   end

   assign io_out       = io_out_q;
   assign pending      = pending_q;
   assign cause        = cause_q;
   assign saved_pc     = saved_pc_q;
   assign in_kernel    = in_kernel_q;
   assign return_pulse = return_pulse_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [15:0] irq_lines;
   logic        mask_we;
   logic [15:0] mask_wdata;
   logic        ack_we;
   logic [15:0] ack_wdata;
   logic        kernel_enter;
   logic        state_fetch;
   logic [15:0] pc;
   logic [15:0] io_out;
   logic [15:0] pending;
   logic [3:0]  cause;
   logic [15:0] saved_pc;
   logic        in_kernel;
   logic        return_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   interrupt_controller #(.NUM_SRC(16), .RETURN_PC(16'd255)) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .irq_lines    (irq_lines),
      .mask_we      (mask_we),
      .mask_wdata   (mask_wdata),
      .ack_we       (ack_we),
      .ack_wdata    (ack_wdata),
      .kernel_enter (kernel_enter),
      .state_fetch  (state_fetch),
      .pc           (pc),
      .io_out       (io_out),
      .pending      (pending),
      .cause        (cause),
      .saved_pc     (saved_pc),
      .in_kernel    (in_kernel),
      .return_pulse (return_pulse)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " io_out"},       32'(io_out),       32'h0);
      check({tag, " pending"},      32'(pending),      32'h0);
      check({tag, " cause"},        32'(cause),        32'h0);
      check({tag, " saved_pc"},     32'(saved_pc),     32'h0);
      check({tag, " in_kernel"},    32'(in_kernel),    32'h0);
      check({tag, " return_pulse"}, 32'(return_pulse), 32'h0);
   endtask

   initial begin
      Reset = 1'b1; irq_lines = 16'h0001; mask_we = 1'b0; mask_wdata = '0;
      ack_we = 1'b0; ack_wdata = '0; kernel_enter = 1'b0; state_fetch = 1'b0;
      pc = 16'h0000;
      tick(); tick();
      Reset = 1'b0;
      check_reset_vals("reset");

      // Line held high through reset: no edge, no request
      mask_we = 1'b1; mask_wdata = 16'hFFFF;
      tick();
      mask_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("held_pending", 32'(pending), 32'h0);
         check("held_io_out",  32'(io_out),  32'h0);
      end

      // kernel_enter outside REQUEST is ignored
      kernel_enter = 1'b1; pc = 16'h0077;
      tick();
      kernel_enter = 1'b0;
      check("ign_in_kernel", 32'(in_kernel), 32'h0);
      check("ign_saved_pc",  32'(saved_pc),  32'h0);

      // Simultaneous edges on bits 5 and 2
      irq_lines = 16'h0025;
      tick();
      check("edge_pending",  32'(pending), 32'h0024);
      check("edge_io_out0",  32'(io_out),  32'h0);
      tick();
      check("edge_io_out1",  32'(io_out),  32'h0004);

      // Kernel entry
      kernel_enter = 1'b1; pc = 16'h0042;
      tick();
      kernel_enter = 1'b0;
      check("ke_cause",     32'(cause),     32'h2);
      check("ke_saved_pc",  32'(saved_pc),  32'h0042);
      check("ke_pending",   32'(pending),   32'h0020);
      check("ke_io_out",    32'(io_out),    32'h0);
      check("ke_in_kernel", 32'(in_kernel), 32'h1);

      // Edge while in kernel: latched but not requested
      irq_lines = 16'h00A5;
      tick();
      check("kern_pending", 32'(pending), 32'h00A0);
      check("kern_io_out",  32'(io_out),  32'h0);
      tick();
      check("kern_io_out2", 32'(io_out),  32'h0);

      // Return: non-matching PC first, then return fetch
      state_fetch = 1'b1; pc = 16'h0100;
      tick();
      check("noret_pulse", 32'(return_pulse), 32'h0);
      pc = 16'd255;
      tick();
      state_fetch = 1'b0; pc = 16'h0010;
      check("ret_pulse",     32'(return_pulse), 32'h1);
      check("ret_in_kernel", 32'(in_kernel),    32'h1);
      tick();
      check("ret1_pulse",     32'(return_pulse), 32'h0);
      check("ret1_in_kernel", 32'(in_kernel),    32'h0);
      check("ret1_io_out",    32'(io_out),       32'h0);
      tick();
      check("ret2_io_out",    32'(io_out),       32'h0020);

      // Higher-priority edge while requesting: io_out tracks it
      irq_lines = 16'h00AD;
      tick();
      check("trk_pending", 32'(pending), 32'h00A8);
      tick();
      check("trk_io_out",  32'(io_out),  32'h0008);

      // Mask everything off: request withdrawn, pending untouched
      mask_we = 1'b1; mask_wdata = 16'h0000;
      tick();
      mask_we = 1'b0;
      tick();
      check("mask_io_out",  32'(io_out),  32'h0);
      check("mask_pending", 32'(pending), 32'h00A8);
      tick();
      check("mask_idle_io", 32'(io_out),  32'h0);

      // Ack coinciding with edge on the same bit keeps it set
      irq_lines = 16'h00AC;
      tick();
      irq_lines = 16'h00AD; ack_we = 1'b1; ack_wdata = 16'h0001;
      tick();
      check("ack_edge_pending", 32'(pending), 32'h00A9);
      ack_wdata = 16'h0008;
      tick();
      ack_we = 1'b0;
      check("ack_clr_pending", 32'(pending), 32'h00A1);

      // Enter kernel on bit 0, then reset mid-kernel
      mask_we = 1'b1; mask_wdata = 16'hFFFF;
      tick();
      mask_we = 1'b0;
      tick();
      check("pre_rst_io_out", 32'(io_out), 32'h0001);
      kernel_enter = 1'b1; pc = 16'h1234;
      tick();
      kernel_enter = 1'b0;
      check("pre_rst_saved_pc",  32'(saved_pc),  32'h1234);
      check("pre_rst_in_kernel", 32'(in_kernel), 32'h1);
      check("pre_rst_pending",   32'(pending),   32'h00A0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check_reset_vals("mid_rst");
      tick();
      check("post_rst_pending", 32'(pending), 32'h0);
      check("post_rst_io_out",  32'(io_out),  32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
